lock_input_guard: RTL and testbench
===================================

# lock_input_guard

Front-end controller for the digital lock state machine. It synchronises and debounces the three raw push-buttons (enter, clear, change). It arbitrates them into at most one clean single-cycle command pulse per two cycles. It enforces a failed-attempt lockout that blocks all commands for a fixed time after repeated wrong passwords. It sits between the board buttons and the lock FSM's `ent`/`clr`/`change` inputs, and consumes the FSM's password-check result.

## Interface
- `DEB_CYCLES`, 50000: consecutive stable cycles required to accept a button level change.
- `TICK_DIV`, 50000000: clock cycles per lockout second.
- `MAX_FAILS`, 3: consecutive failed checks that trigger lockout (1..7).
- `LOCKOUT_SEC`, 30: lockout duration in seconds (1..255).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `btn_ent`, `btn_clr`, `btn_change`  in  1 each  raw asynchronous buttons, active-high.
- `check_done`  in  1  one-cycle pulse from the lock FSM when a password check completes.
- `check_pass`  in  1  check result, valid only while `check_done`=1.
- `ent`, `clr`, `change`  out  1 each  registered one-cycle command pulses; mutually exclusive.
- `lockout`  out  1  high while commands are blocked.
- `fail_cnt`  out  3  consecutive failed checks.
- `remain_sec`  out  8  seconds left in lockout; 0 when not locked out.
- `beat`  out  1  free-running 1 Hz square wave for display blinking.

## Operation
- **Synchronisation:**
  - Each button passes through 2 flops.
- **Debounce:**
  - Each button has its own counter.
  - When the synchronised level differs from the debounced level, the counter increments. When they match, the counter clears.
  - When the counter reaches `DEB_CYCLES`, the debounced level flips and the counter clears.
- **Edge capture:**
  - A rising edge of a debounced level sets that button's pending bit.
  - Falling edges are ignored.
  - A pending bit that is already set stays set; repeat presses merge.
- **Arbiter FSM (ARB_IDLE, ARB_GAP):**
  - In ARB_IDLE with any pending bit set, grant the highest priority: clr > ent > change.
  - The grant clears that pending bit, asserts the matching output for one cycle, and moves to ARB_GAP.
  - Ungranted pending bits are held, not dropped.
  - ARB_GAP lasts exactly one cycle, then returns to ARB_IDLE. This guarantees at least one idle cycle between pulses.
- **Guard FSM (NORMAL, LOCKOUT):**
  - In NORMAL:
    - `check_done` with `check_pass`=1 clears `fail_cnt`.
    - `check_done` with `check_pass`=0 increments `fail_cnt`, saturating at `MAX_FAILS`.
    - If the increment reaches `MAX_FAILS`, enter LOCKOUT on the same edge.
  - On LOCKOUT entry:
    - `remain_sec`=`LOCKOUT_SEC`.
    - The tick counter clears.
    - All pending bits clear.
  - In LOCKOUT:
    - Rising edges do not set pending bits.
    - No command pulses are issued.
    - `check_done` is ignored.
    - The tick counter counts 0..`TICK_DIV`-1. At terminal count, `remain_sec` decrements.
    - When `remain_sec` decrements to 0, return to NORMAL and clear `fail_cnt` on that edge.
- **`beat`:** toggles every `TICK_DIV`/2 cycles, free-running and unaffected by lockout.
- **Widths:**
  - Debounce counters: ceil(log2(`DEB_CYCLES`+1)) bits.
  - Tick and beat counters: ceil(log2(`TICK_DIV`)) bits.
  - All counters wrap or clear explicitly; none wraps silently.

## Timing
- **Reset** (`rst`=0 at an edge, including mid-lockout or mid-debounce), on that edge:
  - All outputs become 0.
  - Both FSMs go to ARB_IDLE/NORMAL.
  - All counters, sync flops, debounced levels and pending bits clear.
- **Press latency:**
  - A raw button rising before edge 0 and held stable produces its output pulse high for the cycle after edge `DEB_CYCLES`+3, provided the arbiter is idle and no higher-priority request is pending.
- **Simultaneous pending requests:**
  - Pulses occur on alternating cycles in priority order.
  - Example: clr and ent pending together give clr at cycle t and ent at cycle t+2.
- **Lockout entry:**
  - `check_done`=1, `check_pass`=0 at edge k with `fail_cnt`=`MAX_FAILS`-1 gives, at edge k+1: `lockout`=1, `fail_cnt`=`MAX_FAILS`, `remain_sec`=`LOCKOUT_SEC`.
- **Lockout duration:**
  - `lockout` stays high exactly `LOCKOUT_SEC`×`TICK_DIV` cycles.
- **Command pulse at entry edge:**
  - A pulse being issued on the same edge as lockout entry still completes.
  - No further pulses are issued afterwards.

## Test plan
Parameters for all scenarios: `DEB_CYCLES`=4, `TICK_DIV`=10, `MAX_FAILS`=3, `LOCKOUT_SEC`=2.

- **Reset:** drive `rst`=0 for 2 cycles with all buttons high -> all outputs 0, then the first `ent` pulse appears 7 cycles after release only if `btn_ent` is held.
- **Debounce:** `btn_ent` glitch high for 3 cycles -> no `ent` pulse. Held high -> exactly one `ent` pulse 7 cycles after the press, and none while it is held.
- **Arbitration:** `btn_clr`, `btn_ent` and `btn_change` rise on the same cycle -> `clr` at t, `ent` at t+2, `change` at t+4, never two pulses high together.
- **Fail counting:** fail, pass, fail -> `fail_cnt` goes 1, 0, 1 and `lockout` stays 0.
- **Lockout:**
  - Three consecutive fails -> `lockout`=1 and `remain_sec`=2.
  - `remain_sec`=1 after 10 cycles, then `lockout`=0 with `fail_cnt`=0 after 20 cycles.
  - Button presses during lockout produce no pulses.
- **Reset mid-lockout:** `rst`=0 at cycle 5 of lockout -> `lockout`=0, `remain_sec`=0 and `fail_cnt`=0 on the next edge.

Source files
------------

// File: rtl/lock_input_guard.sv
// lock_input_guard: button front end for the digital lock.
// Synchronises and debounces three raw buttons, turns their presses into
// spaced single-cycle commands, and blocks all commands for a fixed time
// after too many consecutive failed password checks.
module lock_input_guard #(
    parameter int DEB_CYCLES  = 50000,
    parameter int TICK_DIV    = 50000000,
    parameter int MAX_FAILS   = 3,
    parameter int LOCKOUT_SEC = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_ent,
    input  logic       btn_clr,
    input  logic       btn_change,
    input  logic       check_done,
    input  logic       check_pass,
    output logic       ent,
    output logic       clr,
    output logic       change,
    output logic       lockout,
    output logic [2:0] fail_cnt,
    output logic [7:0] remain_sec,
    output logic       beat
);

    // Counter widths and terminal values.
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] BEAT_LAST = TW'(TICK_DIV / 2 - 1);
    localparam logic [2:0]    FAIL_MAX  = 3'(MAX_FAILS);
    localparam logic [2:0]    FAIL_LAST = 3'(MAX_FAILS - 1);
    localparam logic [7:0]    LOCK_SEC  = 8'(LOCKOUT_SEC);

    // Bit positions of the three buttons inside the packed vectors below.
    localparam int B_ENT = 0;
    localparam int B_CLR = 1;
    localparam int B_CHG = 2;

    typedef enum logic {
        ARB_IDLE,
        ARB_GAP
    } arb_state_t;

    typedef enum logic {
        NORMAL,
        LOCKOUT
    } guard_state_t;

    arb_state_t   arb_state, arb_next;
    guard_state_t guard_state, guard_next;

    logic [2:0]    raw;
    logic [2:0]    sync1, sync2;
    logic [2:0]    deb, deb_d;
    logic [DW-1:0] deb_cnt [3];
    logic [2:0]    rise;
    logic [2:0]    pend, pend_next;
    logic [2:0]    grant;

    logic [TW-1:0] tick_cnt, tick_next;
    logic [TW-1:0] beat_cnt;
    logic [2:0]    fail_next;
    logic [7:0]    remain_next;
    logic          lock_enter;

    assign raw     = {btn_change, btn_clr, btn_ent};
    assign rise    = deb & ~deb_d;
    assign lockout = (guard_state == LOCKOUT);

    // Two-flop synchroniser and per-button debounce counter.
    // NOTE: every clocked block uses non-blocking assignments so that all
    // flops sample their inputs from before the edge, regardless of order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_d <= '0;
            // NOTE: this small counter array sits in flops, not RAM, so it
            // is cleared on reset like any other state.
            for (int i = 0; i < 3; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_d <= deb;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    // This mismatching sample is the DEB_CYCLES-th in a row.
                    deb[i]     <= ~deb[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DW'(1);
                end
            end
        end
    end

    // Arbiter: grant one pending request by priority, then force one idle cycle.
    // NOTE: every signal written here gets a default first, so no path
    // through the block can leave one unassigned and infer a latch.
    always_comb begin
        arb_next = arb_state;
        grant    = '0;
        case (arb_state)
            ARB_IDLE: begin
                if (guard_state == NORMAL && |pend) begin
                    if (pend[B_CLR]) begin
                        grant[B_CLR] = 1'b1;
                    end else if (pend[B_ENT]) begin
                        grant[B_ENT] = 1'b1;
                    end else begin
                        grant[B_CHG] = 1'b1;
                    end
                    arb_next = ARB_GAP;
                end
            end
            ARB_GAP:  arb_next = ARB_IDLE;
            default:  arb_next = ARB_IDLE;
        endcase
    end

    // Guard: count failed checks, enter lockout, and time it down in seconds.
    always_comb begin
        guard_next  = guard_state;
        fail_next   = fail_cnt;
        remain_next = remain_sec;
        tick_next   = tick_cnt;
        lock_enter  = 1'b0;
        case (guard_state)
            NORMAL: begin
                if (check_done) begin
                    if (check_pass) begin
                        fail_next = '0;
                    end else if (fail_cnt >= FAIL_LAST) begin
                        fail_next   = FAIL_MAX;
                        remain_next = LOCK_SEC;
                        tick_next   = '0;
                        guard_next  = LOCKOUT;
                        lock_enter  = 1'b1;
                    end else begin
                        fail_next = fail_cnt + 3'd1;
                    end
                end
            end
            LOCKOUT: begin
                if (tick_cnt == TICK_LAST) begin
                    tick_next = '0;
                    if (remain_sec <= 8'd1) begin
                        // Last second has elapsed: release and forget the failures.
                        remain_next = '0;
                        fail_next   = '0;
                        guard_next  = NORMAL;
                    end else begin
                        remain_next = remain_sec - 8'd1;
                    end
                end else begin
                    tick_next = tick_cnt + TW'(1);
                end
            end
            default: guard_next = NORMAL;
        endcase
    end

    // Pending bits: new rises merge in, grants retire, lockout entry flushes all.
    always_comb begin
        pend_next = pend & ~grant;
        if (guard_state == NORMAL) begin
            pend_next = pend_next | rise;
        end
        if (lock_enter) begin
            pend_next = '0;
        end
    end

    // State registers, counters and registered command pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            arb_state   <= ARB_IDLE;
            guard_state <= NORMAL;
            pend        <= '0;
            fail_cnt    <= '0;
            remain_sec  <= '0;
            tick_cnt    <= '0;
            ent         <= 1'b0;
            clr         <= 1'b0;
            change      <= 1'b0;
        end else begin
            arb_state   <= arb_next;
            guard_state <= guard_next;
            pend        <= pend_next;
            fail_cnt    <= fail_next;
            remain_sec  <= remain_next;
            tick_cnt    <= tick_next;
            ent         <= grant[B_ENT];
            clr         <= grant[B_CLR];
            change      <= grant[B_CHG];
        end
    end

    // Free-running half-period counter for the 1 Hz display beat.
    always_ff @(posedge clk) begin
        if (!rst) begin
            beat_cnt <= '0;
            beat     <= 1'b0;
        end else if (beat_cnt == BEAT_LAST) begin
            beat_cnt <= '0;
            beat     <= ~beat;
        end else begin
            beat_cnt <= beat_cnt + TW'(1);
        end
    end

endmodule

// File: tb/tb_lock_input_guard.sv
// tb_lock_input_guard: directed sequences, a guard vector table and a
// randomized run compared cycle by cycle against a behavioural model.
module tb_lock_input_guard;

    localparam int DEB  = 4;
    localparam int TDIV = 10;
    localparam int MAXF = 3;
    localparam int LSEC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_ent = 1'b0, btn_clr = 1'b0, btn_change = 1'b0;
    logic       check_done = 1'b0, check_pass = 1'b0;
    logic       ent, clr, change, lockout, beat;
    logic [2:0] fail_cnt;
    logic [7:0] remain_sec;

    int tests = 0;
    int fails = 0;

    lock_input_guard #(
        .DEB_CYCLES (DEB),
        .TICK_DIV   (TDIV),
        .MAX_FAILS  (MAXF),
        .LOCKOUT_SEC(LSEC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_ent   (btn_ent),
        .btn_clr   (btn_clr),
        .btn_change(btn_change),
        .check_done(check_done),
        .check_pass(check_pass),
        .ent       (ent),
        .clr       (clr),
        .change    (change),
        .lockout   (lockout),
        .fail_cnt  (fail_cnt),
        .remain_sec(remain_sec),
        .beat      (beat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] dut_vec();
        return {ent, clr, change, lockout, fail_cnt, remain_sec, beat};
    endfunction

    // ---------------- behavioural reference model ----------------
    // Debounce: a level flips once the last DEB synchronised samples all
    // disagree with it. Arbitration: grants at least two edges apart.
    // Lockout: an absolute end time; seconds left = ceil(cycles left / TDIV).
    int         mn;
    int         last_grant;
    int         lock_end;
    int         m_fails;
    logic       m_locked;
    logic [2:0] m_s1, m_s2, m_deb, m_rise, m_pend;
    logic [2:0] sq[$];
    logic [15:0] m_exp;

    task automatic model_step();
        logic [2:0] g, new_deb, new_pend;
        logic       locked, enter, all_diff;
        int         remain;
        if (!rst) begin
            mn = 0; last_grant = -10; lock_end = 0; m_fails = 0; m_locked = 1'b0;
            m_s1 = '0; m_s2 = '0; m_deb = '0; m_rise = '0; m_pend = '0;
            sq.delete();
            m_exp = '0;
            return;
        end
        mn++;
        locked = m_locked;
        sq.push_back(m_s2);
        if (sq.size() > DEB) void'(sq.pop_front());
        new_deb = m_deb;
        for (int b = 0; b < 3; b++) begin
            if (sq.size() == DEB) begin
                all_diff = 1'b1;
                foreach (sq[e]) if (sq[e][b] == m_deb[b]) all_diff = 1'b0;
                if (all_diff) new_deb[b] = ~m_deb[b];
            end
        end
        g = '0;
        if (!locked && m_pend != 3'b000 && mn - last_grant >= 2) begin
            if (m_pend[1])      g = 3'b010;
            else if (m_pend[0]) g = 3'b001;
            else                g = 3'b100;
            last_grant = mn;
        end
        enter = !locked && check_done && !check_pass && (m_fails + 1 >= MAXF);
        new_pend = (m_pend & ~g) | (locked ? 3'b000 : m_rise);
        if (enter) new_pend = '0;
        if (locked) begin
            if (mn == lock_end) m_fails = 0;
        end else if (check_done) begin
            if (check_pass) m_fails = 0;
            else m_fails = (m_fails + 1 >= MAXF) ? MAXF : m_fails + 1;
        end
        if (enter) lock_end = mn + LSEC * TDIV;
        m_locked = (mn < lock_end);
        remain = m_locked ? (lock_end - mn + TDIV - 1) / TDIV : 0;
        m_rise = new_deb & ~m_deb;
        m_deb  = new_deb;
        m_pend = new_pend;
        m_s2   = m_s1;
        m_s1   = {btn_change, btn_clr, btn_ent};
        m_exp  = {g[0], g[1], g[2], m_locked, 3'(m_fails), 8'(remain), 1'((mn / (TDIV / 2)) % 2)};
    endtask

    // One clock: inputs already driven; update the model, then compare off-edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("model", 32'(dut_vec()), 32'(m_exp));
    endtask

    task automatic set_btn(input logic [2:0] v);
        {btn_change, btn_clr, btn_ent} = v;
    endtask

    typedef struct {
        logic       cd;
        logic       cp;
        logic [2:0] exp_fail;
        logic       exp_lock;
        logic [7:0] exp_remain;
    } vec_t;

    vec_t tbl [9];
    int   pulses;
    int   lock_cycles;
    int   hold [3];
    logic [2:0] rnd_btn;

    initial begin
        // ---------- reset with all buttons high ----------
        rst = 1'b0;
        set_btn(3'b111);
        repeat (2) begin
            cycle();
            check("reset_outputs", 32'(dut_vec()), 32'h0);
        end
        set_btn(3'b001);
        rst = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cycle();
            check("release_ent_pulse", 32'({ent, clr, change}), (k == 8) ? 32'h4 : 32'h0);
        end
        set_btn(3'b000);
        repeat (10) cycle();

        // ---------- debounce ----------
        btn_ent = 1'b1;
        repeat (3) cycle();
        btn_ent = 1'b0;
        pulses = 0;
        repeat (15) begin
            cycle();
            pulses += int'(ent);
        end
        check("glitch_no_pulse", 32'(pulses), 32'd0);
        btn_ent = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            cycle();
            check("held_ent_pulse", 32'(ent), (k == 8) ? 32'h1 : 32'h0);
        end
        btn_ent = 1'b0;
        repeat (10) cycle();

        // ---------- arbitration of simultaneous presses ----------
        set_btn(3'b111);
        for (int k = 1; k <= 16; k++) begin
            cycle();
            check("arb_order", 32'({ent, clr, change}),
                  (k == 8) ? 32'h2 : (k == 10) ? 32'h4 : (k == 12) ? 32'h1 : 32'h0);
        end
        set_btn(3'b000);
        repeat (10) cycle();

        // ---------- fail counting and lockout entry (table) ----------
        tbl[0] = '{1'b1, 1'b0, 3'd1, 1'b0, 8'd0};
        tbl[1] = '{1'b0, 1'b0, 3'd1, 1'b0, 8'd0};
        tbl[2] = '{1'b1, 1'b1, 3'd0, 1'b0, 8'd0};
        tbl[3] = '{1'b1, 1'b0, 3'd1, 1'b0, 8'd0};
        tbl[4] = '{1'b1, 1'b0, 3'd2, 1'b0, 8'd0};
        tbl[5] = '{1'b0, 1'b1, 3'd2, 1'b0, 8'd0};
        tbl[6] = '{1'b1, 1'b0, 3'd3, 1'b1, 8'd2};
        tbl[7] = '{1'b1, 1'b1, 3'd3, 1'b1, 8'd2};
        tbl[8] = '{1'b1, 1'b0, 3'd3, 1'b1, 8'd2};
        lock_cycles = 0;
        foreach (tbl[i]) begin
            check_done = tbl[i].cd;
            check_pass = tbl[i].cp;
            cycle();
            lock_cycles += int'(lockout);
            check($sformatf("guard_row%0d", i), 32'({fail_cnt, lockout, remain_sec}),
                  32'({tbl[i].exp_fail, tbl[i].exp_lock, tbl[i].exp_remain}));
        end
        check_done = 1'b0;
        check_pass = 1'b0;

        // ---------- lockout countdown, presses blocked ----------
        btn_clr = 1'b1;
        pulses = 0;
        for (int k = 3; k <= 28; k++) begin
            cycle();
            lock_cycles += int'(lockout);
            pulses += int'(ent | clr | change);
            if (k == 9)  check("remain_before_tick", 32'(remain_sec), 32'd2);
            if (k == 10) check("remain_after_tick", 32'({lockout, remain_sec}), 32'h101);
            if (k == 19) check("lock_last_cycle", 32'({lockout, remain_sec}), 32'h101);
            if (k == 20) check("lock_release", 32'({lockout, fail_cnt, remain_sec}), 32'h0);
        end
        check("lockout_length", 32'(lock_cycles), 32'(LSEC * TDIV));
        check("lockout_no_pulse", 32'(pulses), 32'd0);
        btn_clr = 1'b0;
        repeat (10) cycle();

        // ---------- reset in the middle of a lockout ----------
        repeat (3) begin
            check_done = 1'b1;
            check_pass = 1'b0;
            cycle();
            check_done = 1'b0;
            cycle();
        end
        check("relock", 32'(lockout), 32'h1);
        repeat (4) cycle();
        rst = 1'b0;
        cycle();
        check("reset_mid_lockout", 32'({lockout, fail_cnt, remain_sec}), 32'h0);
        rst = 1'b1;

        // ---------- randomized run against the model ----------
        foreach (hold[b]) hold[b] = 0;
        rnd_btn = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 3; b++) begin
                if (hold[b] == 0) begin
                    rnd_btn[b] = 1'($urandom_range(0, 1));
                    hold[b]    = int'($urandom_range(1, 10));
                end
                hold[b]--;
            end
            set_btn(rnd_btn);
            check_done = ($urandom_range(0, 5) == 0);
            check_pass = ($urandom_range(0, 9) < 3);
            rst        = ($urandom_range(0, 399) != 0);
            cycle();
        end
        rst = 1'b1;
        check_done = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
